alu_op_sequencer: RTL and testbench

- Sequences one ALU operation end to end.
- Captures operand A from the SPI slave's valid strobe, operand B from the debounced operand buttons, and the opcode from the debounced Mult/Sub/And/Xor buttons.
- Drives the structural ALU inputs, waits a settle window, then latches the result for the PWM and 7-segment consumers.
- Replaces the free-running ALU-to-register path with a controlled, error-checked transaction.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_op_sequencer_rise_detect.sv | 23 ++
 rtl/alu_op_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer: FSM state encoding,
// ALU opcode values and the op-button-to-opcode mapping.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3
  } state_e;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  // Maps a one-hot op button vector (bit0 Mult .. bit3 Xor) to its opcode.
  function automatic logic [1:0] btn_to_op(input logic [3:0] btn);
    logic [1:0] op;
    op = OP_MULT;
    if (btn[1]) op = OP_SUB;
    if (btn[2]) op = OP_AND;
    if (btn[3]) op = OP_XOR;
    return op;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_rise_detect.sv
// Rising-edge detector over a W-bit vector of debounced levels.
// The level register clears on reset; the FSM ignores rises while idle.
module rise_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] level_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) level_q <= '0;
    else      level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU transaction: capture A (SPI), B (operand button) and the
// opcode (op buttons), hold ALU inputs for a settle window, latch the result.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] spi_data,
  input  logic       spi_valid,
  input  logic [1:0] opb_code,
  input  logic       opb_press,
  input  logic [3:0] op_btn,
  input  logic [3:0] alu_result,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  output logic [3:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic       err,
  output logic [2:0] state_dbg
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(SETTLE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [3:0]    a_d, b_d, res_d;
  logic [1:0]    op_d;
  logic          err_d, rv_d;
  logic          opb_rise;
  logic [3:0]    op_rise;

  rise_detect #(.W(1)) u_opb_rise (
    .clk   (clk),
    .rst   (rst),
    .level (opb_press),
    .rise  (opb_rise)
  );

  rise_detect #(.W(4)) u_op_rise (
    .clk   (clk),
    .rst   (rst),
    .level (op_btn),
    .rise  (op_rise)
  );

  always_comb begin
    // NOTE: every value is defaulted first so no path through the case
    // leaves a signal unassigned and infers a latch.
    state_d = state_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    a_d     = alu_a;
    b_d     = alu_b;
    op_d    = alu_op;
    res_d   = result;
    err_d   = err;
    rv_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (spi_valid) begin
          a_d     = spi_data;
          err_d   = 1'b0;
          tcnt_d  = '0;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (opb_rise || spi_valid) begin
          if (spi_valid) a_d = spi_data;
          if (opb_rise) begin
            b_d     = {2'b00, opb_code};
            state_d = WAIT_OP;
          end
          tcnt_d = '0;
        end else if (tcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      WAIT_OP: begin
        // A rise with any second button held is ambiguous and aborts.
        if (|op_rise) begin
          if ($onehot(op_btn)) begin
            op_d    = btn_to_op(op_btn);
            scnt_d  = '0;
            state_d = EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      EXEC: begin
        if (scnt_q == ST_LAST) begin
          res_d   = alu_result;
          rv_d    = 1'b1;
          state_d = IDLE;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      scnt_q       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= OP_MULT;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      scnt_q       <= scnt_d;
      alu_a        <= a_d;
      alu_b        <= b_d;
      alu_op       <= op_d;
      result       <= res_d;
      result_valid <= rv_d;
      err          <= err_d;
    end
  end

  assign busy      = (state_q == EXEC);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU model
// and hand-computed expected results.
module tb_alu_op_sequencer;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] spi_data;
  logic       spi_valid;
  logic [1:0] opb_code;
  logic       opb_press;
  logic [3:0] op_btn;
  logic [3:0] alu_result;
  logic [3:0] alu_a, alu_b, result;
  logic [1:0] alu_op;
  logic       result_valid, busy, err;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_data     (spi_data),
    .spi_valid    (spi_valid),
    .opb_code     (opb_code),
    .opb_press    (opb_press),
    .op_btn       (op_btn),
    .alu_result   (alu_result),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  // Structural ALU stand-in, truncated to 4 bits.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      2'b00: alu_result = 4'(alu_a * alu_b);
      2'b01: alu_result = alu_a - alu_b;
      2'b10: alu_result = alu_a & alu_b;
      2'b11: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_spi(input logic [3:0] d);
    spi_data  = d;
    spi_valid = 1'b1;
    tick();
    spi_valid = 1'b0;
  endtask

  task automatic press_b(input logic [1:0] code);
    opb_code  = code;
    opb_press = 1'b1;
    tick();
    opb_press = 1'b0;
  endtask

  task automatic press_op(input logic [3:0] btn);
    op_btn = btn;
    tick();
    op_btn = 4'b0000;
  endtask

  // Called right after the op-rise edge: measures busy length and checks the result.
  task automatic finish_exec(input string tag, input logic [3:0] exp_res);
    int  cnt   = 0;
    bit  early = 0;
    while (busy && cnt < 20) begin
      if (result_valid) early = 1;
      cnt++;
      tick();
    end
    check({tag, "_busy_cycles"}, cnt, SETTLE);
    check({tag, "_early_valid"}, 32'(early), 0);
    check({tag, "_valid"}, result_valid, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, err, 0);
    check({tag, "_state"}, state_dbg, 0);
    tick();
    check({tag, "_valid_drop"}, result_valid, 0);
  endtask

  task automatic count_state(input logic [2:0] st, output int cnt);
    cnt = 0;
    while (state_dbg == st && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  int cyc;

  initial begin
    rst = 1'b0; spi_data = '0; spi_valid = 1'b0;
    opb_code = '0; opb_press = 1'b0; op_btn = '0;
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_result", result, 0);
    check("rst_flags", {result_valid, busy, err}, 0);
    tick(2);
    rst = 1'b1;
    tick();

    // Nominal Sub: 5 - 2 = 3
    pulse_spi(4'd5);
    check("sub_wait_b", state_dbg, 1);
    check("sub_a", alu_a, 5);
    press_b(2'd2);
    check("sub_wait_op", state_dbg, 2);
    check("sub_b", alu_b, 2);
    press_op(4'b0010);
    check("sub_exec", state_dbg, 3);
    check("sub_op", alu_op, 2'b01);
    finish_exec("sub", 4'd3);

    // Mult wrap: 7 * 3 = 21 -> 5
    pulse_spi(4'd7);
    press_b(2'd3);
    press_op(4'b0001);
    check("mult_op", alu_op, 2'b00);
    finish_exec("mult", 4'h5);

    // Two op buttons rising together aborts
    pulse_spi(4'd9);
    press_b(2'd1);
    press_op(4'b0101);
    check("multi_err", err, 1);
    check("multi_state", state_dbg, 0);
    check("multi_result", result, 5);
    check("multi_valid", result_valid, 0);
    pulse_spi(4'd4);
    check("multi_err_clr", err, 0);
    press_b(2'd0);
    press_op(4'b1000);
    finish_exec("xor_zero", 4'd4);

    // Timeout in WAIT_B
    pulse_spi(4'd6);
    count_state(3'd1, cyc);
    check("to_b_cycles", cyc, TIMEOUT);
    check("to_b_err", err, 1);
    check("to_b_state", state_dbg, 0);
    check("to_b_a", alu_a, 6);

    // Timeout in WAIT_OP
    pulse_spi(4'd2);
    check("to_op_err_clr", err, 0);
    press_b(2'd1);
    count_state(3'd2, cyc);
    check("to_op_cycles", cyc, TIMEOUT);
    check("to_op_err", err, 1);
    check("to_op_b", alu_b, 1);

    // Re-capture restarts the timeout; spi during EXEC is dropped
    pulse_spi(4'd3);
    tick(5);
    pulse_spi(4'd12);
    tick(6);
    check("recap_state", state_dbg, 1);
    check("recap_a", alu_a, 12);
    press_b(2'd1);
    press_op(4'b1000);
    spi_data = 4'd15; spi_valid = 1'b1;
    tick();
    spi_valid = 1'b0;
    check("exec_drop_a", alu_a, 12);
    check("exec_drop_busy", busy, 1);
    tick();
    check("recap_valid", result_valid, 1);
    check("recap_result", result, 13);
    check("recap_a_after", alu_a, 12);
    tick();

    // Simultaneous spi_valid and operand press in WAIT_B: 9 - 3 = 6
    pulse_spi(4'd2);
    spi_data = 4'd9; spi_valid = 1'b1; opb_code = 2'd3; opb_press = 1'b1;
    tick();
    spi_valid = 1'b0; opb_press = 1'b0;
    check("both_state", state_dbg, 2);
    check("both_a", alu_a, 9);
    check("both_b", alu_b, 3);
    press_op(4'b0010);
    finish_exec("both", 4'd6);

    // Reset during EXEC, buttons held across release
    pulse_spi(4'd5);
    press_b(2'd2);
    op_btn = 4'b0001;
    tick();
    check("rexec_busy", busy, 1);
    opb_press = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rexec_async_state", state_dbg, 0);
    check("rexec_async_a", alu_a, 0);
    check("rexec_async_b", alu_b, 0);
    check("rexec_async_result", result, 0);
    check("rexec_async_flags", {result_valid, busy, err}, 0);
    tick(2);
    check("rexec_hold_valid", result_valid, 0);
    rst = 1'b1;
    tick();
    check("rexec_post_valid", result_valid, 0);
    pulse_spi(4'd3);
    tick(2);
    check("held_opb_no_rise", state_dbg, 1);
    opb_press = 1'b0;
    tick();
    press_b(2'd1);
    check("held_b", alu_b, 1);
    tick(2);
    check("held_op_no_rise", state_dbg, 2);
    op_btn = 4'b0000;
    tick();
    press_op(4'b0100);
    check("and_op", alu_op, 2'b10);
    finish_exec("and", 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
